// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART transmitter: start, LSB-first data, optional parity, stop bits
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  parity_enable,
    input  logic                  parity_type,
    input  logic [5:0]            prescale,
    output logic                  tx_out,
    output logic                  busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [3:0] DATA_LAST = 4'(DATA_WIDTH - 1);
    localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [5:0]            r_cycle_cnt;
    logic [5:0]            w_cycle_next;
    logic [3:0]            r_bit_cnt;
    logic [3:0]            w_bit_next;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_par_en;
    logic                  r_par_type;
    logic [5:0]            r_prescale;
    logic                  r_tx_out;
    logic                  r_busy;

    logic                  w_accept;
    logic [5:0]            w_last_cnt;
    logic                  w_bit_end;
    logic                  w_parity;
    logic                  w_tx_next;
    logic                  w_busy_next;

    // Prescale 0 wraps to 63 here, giving 64 cycles per bit.
    assign w_last_cnt = r_prescale - 6'd1;
    assign w_bit_end  = (r_cycle_cnt == w_last_cnt);
    assign w_parity   = (^r_data) ^ r_par_type;
    assign w_accept   = (r_state == S_IDLE) && data_valid;

    assign tx_out = r_tx_out;
    assign busy   = r_busy;

    // State, counters, shift register and registered line outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cycle_cnt <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_tx_out    <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cycle_cnt <= w_cycle_next;
            r_bit_cnt   <= w_bit_next;
            r_shift     <= w_shift_next;
            r_tx_out    <= w_tx_next;
            r_busy      <= w_busy_next;
        end
    end

    // Frame parameters captured at acceptance and held for the whole frame.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_data     <= '0;
            r_par_en   <= 1'b0;
            r_par_type <= 1'b0;
            r_prescale <= '0;
        end else if (w_accept) begin
            r_data     <= p_data;
            r_par_en   <= parity_enable;
            r_par_type <= parity_type;
            r_prescale <= prescale;
        end
    end

    // Next-state, counter updates and the line value for the next cycle.
    always_comb begin
        w_state_next = r_state;
        w_cycle_next = r_cycle_cnt;
        w_bit_next   = r_bit_cnt;
        w_shift_next = r_shift;
        w_tx_next    = 1'b1;
        w_busy_next  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cycle_next = '0;
                w_bit_next   = '0;
                if (data_valid) begin
                    w_state_next = S_START;
                    w_shift_next = p_data;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_next = S_DATA;
                    w_cycle_next = '0;
                    w_bit_next   = '0;
                end else begin
                    w_cycle_next = r_cycle_cnt + 6'd1;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_cycle_next = '0;
                    w_shift_next = r_shift >> 1;
                    if (r_bit_cnt == DATA_LAST) begin
                        w_bit_next   = '0;
                        w_state_next = r_par_en ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_next = r_bit_cnt + 4'd1;
                    end
                end else begin
                    w_cycle_next = r_cycle_cnt + 6'd1;
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_next = S_STOP;
                    w_cycle_next = '0;
                    w_bit_next   = '0;
                end else begin
                    w_cycle_next = r_cycle_cnt + 6'd1;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_cycle_next = '0;
                    if (r_bit_cnt == STOP_LAST) begin
                        w_state_next = S_IDLE;
                        w_bit_next   = '0;
                    end else begin
                        w_bit_next = r_bit_cnt + 4'd1;
                    end
                end else begin
                    w_cycle_next = r_cycle_cnt + 6'd1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cycle_next = '0;
                w_bit_next   = '0;
            end
        endcase

        case (w_state_next)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = w_shift_next[0];
            S_PARITY: w_tx_next = w_parity;
            default:  w_tx_next = 1'b1;
        endcase
        w_busy_next = (w_state_next != S_IDLE);
    end

endmodule
